// File: rtl/serial_adder.sv
//==============================================================================
// Module      : serial_adder (with helper cell full_adder)
// Description : Bit-serial WIDTH-bit adder. Latches a, b and cin on start,
//               adds one bit per clock LSB first through a single full_adder
//               cell and a carry flip-flop, then presents registered
//               sum/cout with a one-cycle done pulse.
//               Optional macro SERIAL_ADDER_OVF_EN adds a signed overflow
//               output (ovf) registered alongside sum.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module full_adder (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);
   assign s = x ^ y ^ z;
   assign c = (x & y) | (x & z) | (y & z);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int                c_cnt_w = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_shift_a;
   logic [WIDTH-1:0]   r_shift_b;
   logic [WIDTH-1:0]   r_sum_sr;
   logic               r_carry;
   logic [c_cnt_w-1:0] r_count;

   logic               w_s;
   logic               w_c;
   logic               w_last;
   logic               w_busy_next;
   logic               w_done_next;
   logic [WIDTH-1:0]   w_a_next;
   logic [WIDTH-1:0]   w_b_next;
   logic [WIDTH-1:0]   w_sum_next;

   full_adder u_fa (
      .x (r_shift_a[0]),
      .y (r_shift_b[0]),
      .z (r_carry),
      .s (w_s),
      .c (w_c)
   );

   // Right-shift views; a 1-bit adder has nothing to shift through.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_a_next   = 1'b0;
         assign w_b_next   = 1'b0;
         assign w_sum_next = w_s;
      end else begin : g_wn
         assign w_a_next   = {1'b0, r_shift_a[WIDTH-1:1]};
         assign w_b_next   = {1'b0, r_shift_b[WIDTH-1:1]};
         assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
      end
   endgenerate

   assign w_last = (r_count == c_last);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state decode and next values of the registered status outputs.
   always_comb begin
      w_state_next = r_state;
      w_busy_next  = 1'b0;
      w_done_next  = 1'b0;
      case (r_state)
         IDLE:    if (start) w_state_next = SHIFT;
         SHIFT: begin
            if (w_last) begin
               w_state_next = DONE;
               w_done_next  = 1'b1;
            end
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      w_busy_next = (w_state_next == SHIFT);
   end

   // Datapath: operand load, bit-serial shift, and result capture on the last bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift_a <= '0;
         r_shift_b <= '0;
         r_sum_sr  <= '0;
         r_carry   <= 1'b0;
         r_count   <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         busy <= w_busy_next;
         done <= w_done_next;
         if (r_state == IDLE && start) begin
            r_shift_a <= a;
            r_shift_b <= b;
            r_carry   <= cin;
            r_count   <= '0;
         end else if (r_state == SHIFT) begin
            r_shift_a <= w_a_next;
            r_shift_b <= w_b_next;
            r_sum_sr  <= w_sum_next;
            r_carry   <= w_c;
            r_count   <= r_count + 1'b1;
            if (w_last) begin
               sum  <= w_sum_next;
               cout <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
               // Carry into the MSB is still held in the carry FF here.
               ovf  <= r_carry ^ w_c;
`endif
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around one instance of the team's `full_adder` cell and a carry flip-flop. It latches two operands and a carry-in on a start request, then adds one bit per clock, LSB first. It presents the registered sum and carry-out with a one-cycle done pulse. It is the sequential consumer stage of the `full_adder` cell and trades area for latency against the ripple and lookahead adders in the family.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in, sampled with start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum/cout are updated.
- sum  output  WIDTH  result register.
- cout  output  1  carry-out register.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- Reset: state=IDLE; busy, done, sum, cout, ovf, internal shift registers, carry FF and bit counter are all 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1: load a→shift_a, b→shift_b, cin→carry FF, counter←0, go SHIFT. IDLE, start=0: stay.
- SHIFT, one bit per edge:
  - full_adder inputs x=shift_a[0], y=shift_b[0], z=carry.
  - shift_a and shift_b shift right, 0 in at MSB.
  - s shifts into the sum shift register at MSB.
  - carry←c; counter increments.
- SHIFT, when the counter reaches WIDTH-1 (last bit): in the same edge, sum←final shift value, cout←c, done←1, go DONE.
- DONE: done←0, go IDLE on the next edge.
- start is ignored in SHIFT and DONE. Operands are never re-sampled mid-operation.
- sum and cout hold their last result until the next completion. They never show partial values.
- Counter width is $clog2(WIDTH+1). WIDTH=1 completes in a single SHIFT cycle.
- rst asserted at any time aborts the operation immediately. All outputs return to 0, including previously held sum/cout.

## Timing
- start is sampled at edge E0. Bit i is computed at edge E(i+1).
- At edge E(WIDTH), sum/cout update and done rises. done falls at E(WIDTH+1).
- Latency from start to done is WIDTH edges. Throughput is one addition per WIDTH+2 cycles, because start is only accepted in IDLE.
- busy is 1 from after E0 through E(WIDTH), i.e. while state=SHIFT. busy and done are never both high.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN:
  - Defined: port ovf is present. At the completion edge, ovf←(carry into MSB) XOR (carry out of MSB), i.e. the carry FF value before the last bit XOR c. ovf resets to 0 and holds with sum.
  - Undefined: port ovf and its register do not exist. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- Reset: rst high for 2 cycles with random inputs → busy=0, done=0, sum=0x00, cout=0, ovf=0.
- Basic add: a=0x5A, b=0x33, cin=0, start for 1 cycle → done exactly 8 edges later for 1 cycle, sum=0x8D, cout=0, ovf=1; busy high for 8 cycles.
- Carry and wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1, ovf=0.
- start while busy: a=0x10, b=0x20 started, then start with a=0xAA, b=0x55 at cycle 3 → result is sum=0x30. A second done pulse appears only after a new start in IDLE.
- Reset mid-operation: rst at cycle 4 of an addition → busy=0 immediately, no done pulse, sum=0. A subsequent a=0x01, b=0x01 gives sum=0x02.
- Sweep: 256 random operand/cin triples, compared against {cout,sum} = a+b+cin and the signed overflow reference, with and without SERIAL_ADDER_OVF_EN.
